// File: rtl/stopwatch_bcd_if.sv
// Control and display bundle for stopwatch_bcd: tick/button inputs plus the BCD
// count, lap, running and wrap outputs.
interface stopwatch_bcd_if #(
    parameter int DIGITS = 3
);
    logic                  go;
    logic                  start_stop;
    logic                  clear;
    logic                  lap;
    logic [4*DIGITS-1:0]   count_bcd;
    logic [4*DIGITS-1:0]   lap_bcd;
    logic                  running;
    logic                  wrap;

    modport master (
        output go, start_stop, clear, lap,
        input  count_bcd, lap_bcd, running, wrap
    );

    modport slave (
        input  go, start_stop, clear, lap,
        output count_bcd, lap_bcd, running, wrap
    );
endinterface

// File: rtl/stopwatch_bcd.sv
// BCD stopwatch counting single-cycle go ticks, with start/stop toggle and clear.
// Optional lap capture is enabled by defining STOPWATCH_LAP_EN.
module stopwatch_bcd #(
    parameter int DIGITS = 3
) (
    input  logic             i_clock,
    input  logic             i_reset,
    stopwatch_bcd_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_ss_prev;
    logic                  w_ss_edge;
    logic [4*DIGITS-1:0]   r_count;
    logic [4*DIGITS-1:0]   w_count_inc;
    logic                  w_carry;
    logic                  w_wrap_inc;
    logic                  w_count_en;
    logic                  r_running;
    logic                  r_wrap;

    assign w_ss_edge  = bus.start_stop & ~r_ss_prev;
    assign w_count_en = (r_state == S_RUN) & bus.go & ~bus.clear;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_running <= (w_state_nxt == S_RUN);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.clear) begin
            w_state_nxt = S_IDLE;
        end else if (w_ss_edge) begin
            case (r_state)
                S_IDLE:   w_state_nxt = S_RUN;
                S_RUN:    w_state_nxt = S_PAUSED;
                S_PAUSED: w_state_nxt = S_RUN;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Ripple-carry BCD increment; carry out of the top digit marks the all-9s rollover.
    always_comb begin
        w_carry     = 1'b1;
        w_count_inc = r_count;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_carry) begin
                if (r_count[4*i +: 4] == 4'd9) begin
                    w_count_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_count_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                    w_carry               = 1'b0;
                end
            end
        end
        w_wrap_inc = w_carry;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_ss_prev <= 1'b1;
            r_count   <= '0;
            r_wrap    <= 1'b0;
        end else begin
            r_ss_prev <= bus.start_stop;
            if (bus.clear) begin
                r_count <= '0;
                r_wrap  <= 1'b0;
            end else begin
                if (w_count_en) begin
                    r_count <= w_count_inc;
                end
                r_wrap <= w_count_en & w_wrap_inc;
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic                  r_lap_prev;
    logic                  w_lap_edge;
    logic [4*DIGITS-1:0]   r_lap;

    assign w_lap_edge = bus.lap & ~r_lap_prev;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_lap_prev <= 1'b1;
            r_lap      <= '0;
        end else begin
            r_lap_prev <= bus.lap;
            if (bus.clear) begin
                r_lap <= '0;
            end else if (w_lap_edge) begin
                r_lap <= r_count;
            end
        end
    end

    assign bus.lap_bcd = r_lap;
`else
    logic w_lap_unused;

    assign w_lap_unused = bus.lap;
    assign bus.lap_bcd  = '0;
`endif

    assign bus.count_bcd = r_count;
    assign bus.running   = r_running;
    assign bus.wrap      = r_wrap;
endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed bench for stopwatch_bcd (DIGITS=3) with hand-computed expectations.
// Lap expectations follow STOPWATCH_LAP_EN.
module tb_stopwatch_bcd;
    localparam int DIGITS = 3;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    stopwatch_bcd_if #(.DIGITS(DIGITS)) sw_if ();

    stopwatch_bcd #(.DIGITS(DIGITS)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (sw_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        sw_if.go = 1'b1;
        repeat (n) step();
        sw_if.go = 1'b0;
    endtask

    logic [11:0] lap_exp_047;
    logic [11:0] lap_exp_005;

    initial begin
        n_checks = 0;
        n_errors = 0;
`ifdef STOPWATCH_LAP_EN
        lap_exp_047 = 12'h047;
        lap_exp_005 = 12'h005;
`else
        lap_exp_047 = 12'h000;
        lap_exp_005 = 12'h000;
`endif
        rst              = 1'b1;
        sw_if.go         = 1'b0;
        sw_if.start_stop = 1'b1;
        sw_if.clear      = 1'b0;
        sw_if.lap        = 1'b0;
        repeat (2) step();
        check("rst_count", sw_if.count_bcd, 12'h000);
        check("rst_running", sw_if.running, 1'b0);
        check("rst_wrap", sw_if.wrap, 1'b0);
        check("rst_lap", sw_if.lap_bcd, 12'h000);

        // start_stop held through reset must not start the watch
        rst = 1'b0;
        repeat (2) step();
        check("held_ss_no_start", sw_if.running, 1'b0);
        sw_if.start_stop = 1'b0;
        ticks(2);
        step();
        check("idle_no_count", sw_if.count_bcd, 12'h000);

        sw_if.start_stop = 1'b1;
        step();
        sw_if.start_stop = 1'b0;
        check("start_running", sw_if.running, 1'b1);
        ticks(12);
        step();
        check("count_12", sw_if.count_bcd, 12'h012);

        // stop edge coincident with a tick: tick counts, then paused
        sw_if.start_stop = 1'b1;
        sw_if.go         = 1'b1;
        step();
        sw_if.start_stop = 1'b0;
        sw_if.go         = 1'b0;
        check("ss_go_run_count", sw_if.count_bcd, 12'h013);
        check("ss_go_run_paused", sw_if.running, 1'b0);
        ticks(3);
        check("paused_frozen", sw_if.count_bcd, 12'h013);

        // resume edge coincident with a tick: tick not counted
        sw_if.start_stop = 1'b1;
        sw_if.go         = 1'b1;
        step();
        sw_if.start_stop = 1'b0;
        sw_if.go         = 1'b0;
        check("resume_tick_dropped", sw_if.count_bcd, 12'h013);
        check("resume_running", sw_if.running, 1'b1);

        ticks(34);
        check("count_47", sw_if.count_bcd, 12'h047);
        sw_if.lap = 1'b1;
        step();
        sw_if.lap = 1'b0;
        ticks(3);
        check("lap_count_50", sw_if.count_bcd, 12'h050);
        check("lap_value_47", sw_if.lap_bcd, lap_exp_047);
        check("lap_running", sw_if.running, 1'b1);

        ticks(948);
        check("count_998", sw_if.count_bcd, 12'h998);
        sw_if.go = 1'b1;
        step();
        check("count_999", sw_if.count_bcd, 12'h999);
        check("no_wrap_999", sw_if.wrap, 1'b0);
        step();
        sw_if.go = 1'b0;
        check("rollover_000", sw_if.count_bcd, 12'h000);
        check("wrap_pulse", sw_if.wrap, 1'b1);
        check("wrap_running", sw_if.running, 1'b1);
        step();
        check("wrap_one_cycle", sw_if.wrap, 1'b0);
        check("continues_after_wrap", sw_if.lap_bcd, lap_exp_047);

        ticks(5);
        check("count_5", sw_if.count_bcd, 12'h005);
        sw_if.lap = 1'b1;
        step();
        sw_if.lap = 1'b0;
        check("lap_value_5", sw_if.lap_bcd, lap_exp_005);

        // clear with a simultaneous tick in RUN
        sw_if.clear = 1'b1;
        sw_if.go    = 1'b1;
        step();
        sw_if.clear = 1'b0;
        sw_if.go    = 1'b0;
        check("clear_count", sw_if.count_bcd, 12'h000);
        check("clear_lap", sw_if.lap_bcd, 12'h000);
        check("clear_running", sw_if.running, 1'b0);
        check("clear_wrap", sw_if.wrap, 1'b0);
        ticks(2);
        check("clear_idle", sw_if.count_bcd, 12'h000);

        // reset in the middle of counting
        sw_if.start_stop = 1'b1;
        step();
        sw_if.start_stop = 1'b0;
        ticks(7);
        check("count_7", sw_if.count_bcd, 12'h007);
        rst      = 1'b1;
        sw_if.go = 1'b1;
        step();
        rst      = 1'b0;
        sw_if.go = 1'b0;
        check("midrst_count", sw_if.count_bcd, 12'h000);
        check("midrst_running", sw_if.running, 1'b0);
        ticks(2);
        check("midrst_idle", sw_if.count_bcd, 12'h000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
